// File: rtl/bank_ctrl.sv
// bank_ctrl: initiator side of the 8-bit memory bank interface.
// Takes one read or write request at a time from the client over a
// valid/ready handshake, drives the bank pins from registers, captures the
// bank's registered data_out/valid_out and holds it as the read response
// until the client takes it.
//
// Optional build macro: BANK_CTRL_FILL_EN
//   When defined, the controller writes FILL_VALUE to every bank address
//   after reset, one address per cycle, before it accepts any request.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; req_ready high
// ISSUE   | bank enable high for this single cycle; bank samples at the edge
// CAPTURE | bank data_out/valid_out valid; latched into resp_data/resp_hit
// RESP    | resp_valid high until the client handshakes
// FILL    | (BANK_CTRL_FILL_EN only) post-reset sweep writing FILL_VALUE
module bank_ctrl #(
    parameter int unsigned           ADDR_W     = 8,
    parameter int unsigned           DATA_W     = 8,
    parameter logic [DATA_W-1:0]     FILL_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,

    output logic              busy,

    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_data_in,
    output logic              bank_read_enable,
    output logic              bank_write_enable,
    input  logic [DATA_W-1:0] bank_data_out,
    input  logic              bank_valid_out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RESP    = 3'd3
`ifdef BANK_CTRL_FILL_EN
        , ST_FILL  = 3'd4
`endif
    } state_t;

`ifdef BANK_CTRL_FILL_EN
    localparam state_t RESET_STATE = ST_FILL;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   bank_addr_q, bank_addr_d;
    logic [DATA_W-1:0]   bank_data_in_q, bank_data_in_d;
    logic                bank_re_q, bank_re_d;
    logic                bank_we_q, bank_we_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_hit_q, resp_hit_d;
`ifdef BANK_CTRL_FILL_EN
    logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
`endif

    // State and all registered outputs; everything clears on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RESET_STATE;
            bank_addr_q    <= '0;
            bank_data_in_q <= '0;
            bank_re_q      <= 1'b0;
            bank_we_q      <= 1'b0;
            resp_data_q    <= '0;
            resp_hit_q     <= 1'b0;
`ifdef BANK_CTRL_FILL_EN
            fill_cnt_q     <= '0;
`endif
        end else begin
            state_q        <= state_d;
            bank_addr_q    <= bank_addr_d;
            bank_data_in_q <= bank_data_in_d;
            bank_re_q      <= bank_re_d;
            bank_we_q      <= bank_we_d;
            resp_data_q    <= resp_data_d;
            resp_hit_q     <= resp_hit_d;
`ifdef BANK_CTRL_FILL_EN
            fill_cnt_q     <= fill_cnt_d;
`endif
        end
    end

    // Next-state and next-register values; enables default low so each
    // access pulses for exactly one cycle and read/write never overlap.
    always_comb begin
        state_d        = state_q;
        bank_addr_d    = bank_addr_q;
        bank_data_in_d = bank_data_in_q;
        bank_re_d      = 1'b0;
        bank_we_d      = 1'b0;
        resp_data_d    = resp_data_q;
        resp_hit_d     = resp_hit_q;
`ifdef BANK_CTRL_FILL_EN
        fill_cnt_d     = fill_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // req_ready is high in IDLE, so req_valid alone means accept.
                if (req_valid) begin
                    bank_addr_d    = req_addr;
                    bank_data_in_d = req_wdata;
                    bank_we_d      = req_we;
                    bank_re_d      = !req_we;
                    state_d        = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Writes finish here with no response; reads wait for data.
                state_d = bank_we_q ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                resp_data_d = bank_data_out;
                resp_hit_d  = bank_valid_out;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef BANK_CTRL_FILL_EN
            ST_FILL: begin
                bank_we_d      = 1'b1;
                bank_addr_d    = fill_cnt_q;
                bank_data_in_d = FILL_VALUE;
                fill_cnt_d     = fill_cnt_q + 1'b1;
                // The last address is still on the pins during the first
                // IDLE cycle; the bank samples it at that cycle's edge.
                if (fill_cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs depend on state only; reset gates req_ready so no
    // request is taken while reset is held.
    assign req_ready         = (state_q == ST_IDLE) && !reset;
    assign resp_valid        = (state_q == ST_RESP);
    assign busy              = (state_q != ST_IDLE);
    assign resp_data         = resp_data_q;
    assign resp_hit          = resp_hit_q;
    assign bank_addr         = bank_addr_q;
    assign bank_data_in      = bank_data_in_q;
    assign bank_read_enable  = bank_re_q;
    assign bank_write_enable = bank_we_q;

endmodule

// File: tb/tb_bank_ctrl.sv
// Testbench for bank_ctrl (default build, fill sweep off).
// Contains a behavioural model of the bank (registered data_out/valid_out,
// valid bit per location cleared only by the bank's own reset).
module tb_bank_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        bank_rst;
    logic        req_valid, req_ready, req_we;
    logic [7:0]  req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_hit;
    logic [7:0]  resp_data;
    logic        busy;
    logic [7:0]  bank_addr, bank_data_in, bank_data_out;
    logic        bank_read_enable, bank_write_enable, bank_valid_out;

    always #5 clk = ~clk;

    bank_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_data         (resp_data),
        .resp_hit          (resp_hit),
        .busy              (busy),
        .bank_addr         (bank_addr),
        .bank_data_in      (bank_data_in),
        .bank_read_enable  (bank_read_enable),
        .bank_write_enable (bank_write_enable),
        .bank_data_out     (bank_data_out),
        .bank_valid_out    (bank_valid_out)
    );

    // Bank model
    logic [7:0]   mem [256];
    logic [255:0] mvld;
    always @(posedge clk or posedge bank_rst) begin
        if (bank_rst) begin
            mvld           <= '0;
            bank_data_out  <= '0;
            bank_valid_out <= 1'b0;
        end else begin
            if (bank_write_enable) begin
                mem[bank_addr]  <= bank_data_in;
                mvld[bank_addr] <= 1'b1;
            end
            if (bank_read_enable) begin
                bank_data_out  <= mem[bank_addr];
                bank_valid_out <= mvld[bank_addr];
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       hit;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         hold;
        logic [7:0] exp_data;
        logic       exp_hit;
    } vec_t;
    vec_t vecs[12];

    // Read and write enables must never be high together.
    always @(negedge clk) begin
        if (!reset) chk("en_overlap", 32'(bank_read_enable & bank_write_enable), 32'd0);
    end

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_unexpected_resp"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_resp_hit"}, 32'(resp_hit), 32'(e.hit));
            if (e.hit) chk({tag, "_resp_data"}, 32'(resp_data), 32'(e.data));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit seen;
        logic [7:0] d0;
        logic h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        if (!v.we) sb_q.push_back('{v.exp_data, v.exp_hit});
        @(negedge clk);
        // Garbage on req_* while not ready must be ignored.
        req_valid = 1'b0; req_we = !v.we; req_addr = ~v.addr; req_wdata = ~v.wdata;
        chk("issue_we",    32'(bank_write_enable), 32'(v.we));
        chk("issue_re",    32'(bank_read_enable),  32'(!v.we));
        chk("issue_addr",  32'(bank_addr),         32'(v.addr));
        chk("issue_ready", 32'(req_ready),         32'd0);
        if (v.we) chk("issue_wdata", 32'(bank_data_in), 32'(v.wdata));
        @(negedge clk);
        chk("post_issue_we", 32'(bank_write_enable), 32'd0);
        chk("post_issue_re", 32'(bank_read_enable),  32'd0);
        if (v.we) begin
            chk("write_done_ready", 32'(req_ready),  32'd1);
            chk("write_no_resp",    32'(resp_valid), 32'd0);
            return;
        end
        chk("capture_no_resp", 32'(resp_valid), 32'd0);
        n = 0; seen = 1'b0;
        while (n < 10 && !seen) begin @(negedge clk); n++; seen = resp_valid; end
        chk("read_latency", 32'(n + 2), 32'd3);
        if (!seen) return;
        d0 = resp_data; h0 = resp_hit;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data",  32'(resp_data),  32'(d0));
            chk("hold_hit",   32'(resp_hit),   32'(h0));
            chk("hold_ready", 32'(req_ready),  32'd0);
        end
        resp_ready = 1'b1;
        pop_cmp("vec");
        @(negedge clk);
        resp_ready = 1'b0;
        chk("after_hs_valid", 32'(resp_valid), 32'd0);
        chk("after_hs_ready", 32'(req_ready),  32'd1);
        chk("after_hs_busy",  32'(busy),       32'd0);
        chk("after_hs_data",  32'(resp_data),  32'(d0));
    endtask

    initial begin
        int n;
        reset = 1'b1; bank_rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

        //           we    addr   wdata  hold exp_data exp_hit
        vecs[0]  = '{1'b1, 8'h10, 8'h3C, 0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h10, 8'h00, 0, 8'h3C, 1'b1};
        vecs[2]  = '{1'b0, 8'h55, 8'h00, 0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h10, 8'h00, 5, 8'h3C, 1'b1};
        vecs[4]  = '{1'b1, 8'h20, 8'hA7, 0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 8'h20, 8'h00, 2, 8'hA7, 1'b1};
        vecs[6]  = '{1'b1, 8'h20, 8'h5A, 0, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 8'h20, 8'h00, 0, 8'h5A, 1'b1};
        vecs[8]  = '{1'b0, 8'hFF, 8'h00, 1, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, 8'hFF, 8'h01, 0, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 8'hFF, 8'h00, 0, 8'h01, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b0};

        #2;
        chk("rst_req_ready",  32'(req_ready),         32'd0);
        chk("rst_resp_valid", 32'(resp_valid),        32'd0);
        chk("rst_busy",       32'(busy),              32'd0);
        chk("rst_re",         32'(bank_read_enable),  32'd0);
        chk("rst_we",         32'(bank_write_enable), 32'd0);
        chk("rst_addr",       32'(bank_addr),         32'd0);
        chk("rst_data_in",    32'(bank_data_in),      32'd0);
        chk("rst_resp_data",  32'(resp_data),         32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0; bank_rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Back-to-back writes with req_valid held: one accept per 2 cycles.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_wdata = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            req_addr = 8'(i);
            chk("burst_ready",   32'(req_ready),         32'd1);
            chk("burst_idle_we", 32'(bank_write_enable), 32'd0);
            @(negedge clk);
            chk("burst_we",    32'(bank_write_enable), 32'd1);
            chk("burst_re",    32'(bank_read_enable),  32'd0);
            chk("burst_addr",  32'(bank_addr),         32'(i));
            chk("burst_data",  32'(bank_data_in),      32'hFF);
            chk("burst_nrdy",  32'(req_ready),         32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        run_vec('{1'b0, 8'h02, 8'h00, 0, 8'hFF, 1'b1});
        run_vec('{1'b0, 8'h00, 8'h00, 0, 8'hFF, 1'b1});

        // Reset while a read response is pending: response is dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        chk("rr_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 10) begin @(negedge clk); n++; end
        chk("rr_resp_valid", 32'(resp_valid), 32'd1);
        chk("rr_resp_data",  32'(resp_data),  32'h3C);
        chk("rr_resp_hit",   32'(resp_hit),   32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rr_clr_valid", 32'(resp_valid),        32'd0);
        chk("rr_clr_data",  32'(resp_data),         32'd0);
        chk("rr_clr_hit",   32'(resp_hit),          32'd0);
        chk("rr_clr_re",    32'(bank_read_enable),  32'd0);
        chk("rr_clr_we",    32'(bank_write_enable), 32'd0);
        chk("rr_clr_ready", 32'(req_ready),         32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rr_release_ready", 32'(req_ready),  32'd1);
        chk("rr_release_valid", 32'(resp_valid), 32'd0);
        chk("rr_release_busy",  32'(busy),       32'd0);

        // Bank kept its contents across controller reset.
        run_vec('{1'b0, 8'h10, 8'h00, 0, 8'h3C, 1'b1});

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
